mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single byte-wide MemoryAccessor port (ready/address/read/read_value/write/write_value)
//  between two requesters: port 0 = CPU instruction fetch, port 1 = CPU data load/store.
//  Latches one pending request per port, grants round-robin, and drives one memory transaction
//  at a time. Returns read data plus a one-cycle done pulse to the owning port.
// PARAMETERS
//  ADDR_W   `ARCH_SIZE  address width; matches the MemoryAccessor address bus
//  TIMEOUT  255         cycles a BUSY transaction waits for mem_ready (MEM_ARB_TIMEOUT_EN only); 8-bit counter
// PORTS
//  clock        in   1       single clock; all logic on the rising edge
//  reset        in   1       synchronous, active-high
//  req0_valid   in   1       port 0 request strobe; sampled only while req0_busy=0
//  req0_write   in   1       port 0 direction: 1 = write, 0 = read
//  req0_addr    in   ADDR_W  port 0 address
//  req0_wdata   in   8       port 0 write data
//  req0_busy    out  1       port 0 request pending or in flight
//  req0_done    out  1       one-cycle pulse: port 0 transaction complete
//  req0_rdata   out  8       port 0 read data; valid with req0_done, held until the next port-0 done
//  req1_*       --   --      identical set for port 1
//  mem_ready    in   1       memory completion strobe; read_value valid in the same cycle
//  mem_address  out  ADDR_W  held stable for the whole transaction
//  mem_read     out  1       level; high from grant until the completion edge
//  mem_rdata    in   8       read_value from memory
//  mem_write    out  1       level; high from grant until the completion edge
//  mem_wdata    out  8       held stable while mem_write=1
//  timeout      out  1       one-cycle pulse on abort (present only with MEM_ARB_TIMEOUT_EN)
// BEHAVIOUR
//  Reset values:
//   - all outputs 0; both pending slots empty; state IDLE; last_grant=1 (port 0 wins first tie).
//   - Reset mid-transaction drops mem_read/mem_write on the next edge with no done pulse.
//  Request capture:
//   - A rising edge with reqN_valid=1 and reqN_busy=0 latches write/addr/wdata into slot N.
//   - reqN_busy=1 from the next cycle. reqN_valid while busy is ignored; no queueing beyond 1.
//  FSM IDLE -> BUSY:
//   - In IDLE with >=1 slot pending, grant and go BUSY.
//   - Both pending: grant the port != last_grant. One pending: grant it.
//   - On that edge, register mem_address/mem_wdata from the slot and set mem_read or mem_write.
//   - last_grant := granted port.
//   - A request latched on edge k is granted at the earliest on edge k+1.
//  FSM BUSY -> IDLE:
//   - In BUSY, on an edge with mem_ready=1:
//     - clear mem_read/mem_write;
//     - reads: reqN_rdata := mem_rdata;
//     - reqN_done=1 for one cycle; slot N cleared (reqN_busy=0 that same cycle); state IDLE.
//  Timing:
//   - Zero-wait memory (ready in the first BUSY cycle) gives 3 edges from valid to the done cycle.
//   - One transaction at most every 2 cycles.
//   - mem_ready in IDLE is ignored.
//  Simultaneous events:
//   - reqN_valid in the same cycle reqN_done is high is accepted (busy already 0).
//   - A request to the other port arriving during BUSY waits; it is granted on the IDLE edge.
//   - Never assert mem_read and mem_write together. Write data is never returned as rdata.
// CONFIGURATION
//  MEM_ARB_TIMEOUT_EN defined:
//   - 8-bit counter cleared on grant, incremented each BUSY cycle without mem_ready.
//   - When the count reaches TIMEOUT (with mem_ready=0): drop read/write, go IDLE, clear the slot.
//   - Pulse reqN_done and timeout together; reqN_rdata := 8'hFF for reads.
//   - mem_ready on the same edge wins (normal completion).
//  MEM_ARB_TIMEOUT_EN undefined: no counter, no timeout port; BUSY waits indefinitely.
// TESTING
//  1. Port-0 read addr 0x0010, memory returns 0xA5 with ready in the first BUSY cycle
//     -> mem_read high 1 cycle, req0_done with req0_rdata=0xA5 on the 3rd edge after valid.
//  2. Port-1 write 0x3C to 0x0200, ready delayed 4 cycles
//     -> mem_write/mem_address/mem_wdata stable all 5 BUSY cycles, req1_done once, req1_rdata unchanged.
//  3. Both valid on the same edge after reset -> port 0 served first, then port 1.
//     Repeat the simultaneous request -> port 0 served first again (last_grant=1).
//     Then port 1 then port 0 pending together -> round-robin order holds.
//  4. req0_valid pulsed again while req0_busy=1 with a different addr -> ignored; only the first address appears.
//     Valid in the done cycle -> accepted.
//  5. Reset asserted in BUSY -> next edge: mem_read=0, busy=0, no done.
//     First request after reset completes normally.
//  6. (MEM_ARB_TIMEOUT_EN, TIMEOUT=4) ready never asserted -> abort after 4 BUSY cycles: timeout+done pulse, rdata=0xFF.
//     Ready on the 4th cycle -> normal data, no timeout.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter onto the single byte-wide MemoryAccessor port.
// Optional BUSY watchdog is compiled in when MEM_ARB_TIMEOUT_EN is defined.
`ifndef ARCH_SIZE
`define ARCH_SIZE 16
`endif

module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = `ARCH_SIZE
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [7:0]        req0_wdata,
    output logic              req0_busy,
    output logic              req0_done,
    output logic [7:0]        req0_rdata,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [7:0]        req1_wdata,
    output logic              req1_busy,
    output logic              req1_done,
    output logic [7:0]        req1_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    input  logic [7:0]        mem_rdata,
    output logic              mem_write,
    output logic [7:0]        mem_wdata
`ifdef MEM_ARB_TIMEOUT_EN
    ,
    output logic              timeout
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [1:0]        slot_vld_q, slot_vld_d;
    logic [1:0]        slot_wr_q, slot_wr_d;
    logic [ADDR_W-1:0] slot_addr_q [2];
    logic [ADDR_W-1:0] slot_addr_d [2];
    logic [7:0]        slot_wdata_q [2];
    logic [7:0]        slot_wdata_d [2];
    logic              owner_q, owner_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [7:0]        mem_wdata_q, mem_wdata_d;
    logic [1:0]        done_q, done_d;
    logic [7:0]        rdata_q [2];
    logic [7:0]        rdata_d [2];
    logic              gnt;

    logic [1:0]        req_valid, req_write;
    logic [ADDR_W-1:0] req_addr [2];
    logic [7:0]        req_wdata [2];

`ifdef MEM_ARB_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
`endif

    assign req_valid    = {req1_valid, req0_valid};
    assign req_write    = {req1_write, req0_write};
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    always_comb begin
        state_d       = state_q;
        slot_vld_d    = slot_vld_q;
        slot_wr_d     = slot_wr_q;
        slot_addr_d   = slot_addr_q;
        slot_wdata_d  = slot_wdata_q;
        owner_d       = owner_q;
        last_grant_d  = last_grant_q;
        mem_address_d = mem_address_q;
        mem_read_d    = mem_read_q;
        mem_write_d   = mem_write_q;
        mem_wdata_d   = mem_wdata_q;
        done_d        = '0;
        rdata_d       = rdata_q;
        gnt           = 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
        cnt_d         = cnt_q;
        timeout_d     = 1'b0;
`endif

        for (int unsigned n = 0; n < 2; n++) begin
            if (req_valid[n] && !slot_vld_q[n]) begin
                slot_vld_d[n]   = 1'b1;
                slot_wr_d[n]    = req_write[n];
                slot_addr_d[n]  = req_addr[n];
                slot_wdata_d[n] = req_wdata[n];
            end
        end

        unique case (state_q)
            IDLE: begin
                // Grant decision looks only at slots latched on earlier edges.
                if (|slot_vld_q) begin
                    gnt           = (&slot_vld_q) ? ~last_grant_q : slot_vld_q[1];
                    owner_d       = gnt;
                    last_grant_d  = gnt;
                    mem_address_d = slot_addr_q[gnt];
                    mem_wdata_d   = slot_wdata_q[gnt];
                    mem_read_d    = ~slot_wr_q[gnt];
                    mem_write_d   = slot_wr_q[gnt];
                    state_d       = BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt_d         = '0;
`endif
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    if (mem_read_q) rdata_d[owner_q] = mem_rdata;
                    mem_read_d          = 1'b0;
                    mem_write_d         = 1'b0;
                    done_d[owner_q]     = 1'b1;
                    slot_vld_d[owner_q] = 1'b0;
                    state_d             = IDLE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    if (mem_read_q) rdata_d[owner_q] = 8'hFF;
                    mem_read_d          = 1'b0;
                    mem_write_d         = 1'b0;
                    done_d[owner_q]     = 1'b1;
                    slot_vld_d[owner_q] = 1'b0;
                    timeout_d           = 1'b1;
                    state_d             = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            slot_vld_q    <= '0;
            slot_wr_q     <= '0;
            slot_addr_q   <= '{default: '0};
            slot_wdata_q  <= '{default: '0};
            owner_q       <= 1'b0;
            last_grant_q  <= 1'b1;
            mem_address_q <= '0;
            mem_read_q    <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            done_q        <= '0;
            rdata_q       <= '{default: '0};
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q         <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            slot_vld_q    <= slot_vld_d;
            slot_wr_q     <= slot_wr_d;
            slot_addr_q   <= slot_addr_d;
            slot_wdata_q  <= slot_wdata_d;
            owner_q       <= owner_d;
            last_grant_q  <= last_grant_d;
            mem_address_q <= mem_address_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            mem_wdata_q   <= mem_wdata_d;
            done_q        <= done_d;
            rdata_q       <= rdata_d;
`ifdef MEM_ARB_TIMEOUT_EN
            cnt_q         <= cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    assign req0_busy   = slot_vld_q[0];
    assign req1_busy   = slot_vld_q[1];
    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];
    assign req0_rdata  = rdata_q[0];
    assign req1_rdata  = rdata_q[1];
    assign mem_address = mem_address_q;
    assign mem_read    = mem_read_q;
    assign mem_write   = mem_write_q;
    assign mem_wdata   = mem_wdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign timeout     = timeout_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level model compared every cycle,
// plus directed literal checks. Timeout cases build only with MEM_ARB_TIMEOUT_EN.
module tb_mem_port_arbiter;

    localparam int AW = 16;
`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TB_TIMEOUT = 4;
`endif

    logic          clock, reset;
    logic          req0_valid, req0_write, req0_busy, req0_done;
    logic [AW-1:0] req0_addr;
    logic [7:0]    req0_wdata, req0_rdata;
    logic          req1_valid, req1_write, req1_busy, req1_done;
    logic [AW-1:0] req1_addr;
    logic [7:0]    req1_wdata, req1_rdata;
    logic          mem_ready, mem_read, mem_write;
    logic [AW-1:0] mem_address;
    logic [7:0]    mem_rdata, mem_wdata;
`ifdef MEM_ARB_TIMEOUT_EN
    logic          timeout;
`endif

    mem_port_arbiter #(
        .ADDR_W(AW)
`ifdef MEM_ARB_TIMEOUT_EN
        , .TIMEOUT(TB_TIMEOUT)
`endif
    ) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_busy(req0_busy), .req0_done(req0_done),
        .req0_rdata(req0_rdata),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_busy(req1_busy), .req1_done(req1_done),
        .req1_rdata(req1_rdata),
        .mem_ready(mem_ready), .mem_address(mem_address), .mem_read(mem_read),
        .mem_rdata(mem_rdata), .mem_write(mem_write), .mem_wdata(mem_wdata)
`ifdef MEM_ARB_TIMEOUT_EN
        , .timeout(timeout)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory responder: ready after ready_delay cycles of an active transaction.
    int         ready_delay = 0;
    int         act_cnt = 0;
    logic       idle_ready = 1'b0;
    initial begin
        mem_ready = 1'b0;
        mem_rdata = 8'h00;
    end
    always @(posedge clock) begin
        #1;
        if (mem_read || mem_write) begin
            mem_ready = (act_cnt == ready_delay);
            act_cnt++;
        end else begin
            act_cnt   = 0;
            mem_ready = idle_ready;
        end
    end

    // Transaction-level reference: pending requests, the one in flight, and port results.
    typedef struct {
        bit            v;
        bit            wr;
        logic [AW-1:0] a;
        logic [7:0]    d;
    } pend_t;
    pend_t         pend [2];
    int            cur = -1;
    int            waited = 0;
    int            m_last = 1;
    bit   [1:0]    m_done = '0;
    bit            m_to = 1'b0;
    logic [7:0]    m_rdata [2];
    logic [AW-1:0] m_addr;
    logic [7:0]    m_wd;
    bit            m_rd = 1'b0, m_wr = 1'b0;
    bit            started = 1'b0;

    always @(posedge clock) begin : model
        bit            ov [2];
        bit            vin [2];
        bit            win [2];
        logic [AW-1:0] ain [2];
        logic [7:0]    din [2];
        int            g;
        vin[0] = req0_valid; win[0] = req0_write; ain[0] = req0_addr; din[0] = req0_wdata;
        vin[1] = req1_valid; win[1] = req1_write; ain[1] = req1_addr; din[1] = req1_wdata;
        ov[0] = pend[0].v; ov[1] = pend[1].v;
        m_done = '0;
        m_to = 1'b0;
        started = 1'b1;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                pend[i].v = 0; m_rdata[i] = 8'h00;
            end
            cur = -1; m_last = 1; m_rd = 0; m_wr = 0; m_addr = '0; m_wd = '0;
        end else begin
            if (cur >= 0) begin
                if (mem_ready) begin
                    if (!pend[cur].wr) m_rdata[cur] = mem_rdata;
                    m_done[cur] = 1; pend[cur].v = 0; cur = -1; m_rd = 0; m_wr = 0;
                end else begin
                    waited++;
`ifdef MEM_ARB_TIMEOUT_EN
                    if (waited == TB_TIMEOUT) begin
                        if (!pend[cur].wr) m_rdata[cur] = 8'hFF;
                        m_done[cur] = 1; m_to = 1; pend[cur].v = 0; cur = -1; m_rd = 0; m_wr = 0;
                    end
`endif
                end
            end else if (ov[0] || ov[1]) begin
                if (ov[0] && ov[1]) g = 1 - m_last;
                else g = ov[0] ? 0 : 1;
                cur = g; m_last = g; waited = 0;
                m_addr = pend[g].a; m_wd = pend[g].d;
                m_rd = !pend[g].wr; m_wr = pend[g].wr;
            end
            for (int i = 0; i < 2; i++) begin
                if (vin[i] && !ov[i]) begin
                    pend[i].v = 1; pend[i].wr = win[i]; pend[i].a = ain[i]; pend[i].d = din[i];
                end
            end
        end
    end

    logic [AW-1:0] glog [$];
    bit            prev_act = 1'b0;

    always @(negedge clock) begin : compare
        if (started) begin
            check("busy0", req0_busy, pend[0].v);
            check("busy1", req1_busy, pend[1].v);
            check("done0", req0_done, m_done[0]);
            check("done1", req1_done, m_done[1]);
            check("rdata0", req0_rdata, m_rdata[0]);
            check("rdata1", req1_rdata, m_rdata[1]);
            check("mem_read", mem_read, m_rd);
            check("mem_write", mem_write, m_wr);
            check("rd_wr_exclusive", mem_read & mem_write, 0);
            if (m_rd || m_wr) check("mem_address", mem_address, m_addr);
            if (m_wr) check("mem_wdata", mem_wdata, m_wd);
`ifdef MEM_ARB_TIMEOUT_EN
            check("timeout", timeout, m_to);
`endif
            if ((mem_read || mem_write) && !prev_act) glog.push_back(mem_address);
            prev_act = mem_read || mem_write;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((req0_busy || req1_busy || mem_read || mem_write) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) begin
            checks++; errors++;
            $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
        end
        tick();
    endtask

    task automatic expect_log(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        logic [AW-1:0] g0, g1;
        g0 = (glog.size() > 0) ? glog[0] : '1;
        g1 = (glog.size() > 1) ? glog[1] : '1;
        check("grant_count", glog.size(), 2);
        check("grant_first", g0, a0);
        check("grant_second", g1, a1);
        glog.delete();
    endtask

    task automatic both_read(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        req0_valid = 1; req0_write = 0; req0_addr = a0;
        req1_valid = 1; req1_write = 0; req1_addr = a1;
        tick();
        req0_valid = 0; req1_valid = 0;
        wait_idle(30);
    endtask

    initial begin : stim
        int n;
        reset = 1;
        req0_valid = 0; req0_write = 0; req0_addr = '0; req0_wdata = '0;
        req1_valid = 0; req1_write = 0; req1_addr = '0; req1_wdata = '0;
        tick(); tick();
        check("rst_mem_read", mem_read, 0);
        check("rst_mem_address", mem_address, 0);
        check("rst_busy0", req0_busy, 0);
        check("rst_rdata1", req1_rdata, 0);
        reset = 0;
        tick();

        // Zero-wait read: done on the third edge after valid.
        ready_delay = 0; mem_rdata = 8'hA5;
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0010;
        tick();
        req0_valid = 0;
        check("t1_busy_after_latch", req0_busy, 1);
        check("t1_no_read_yet", mem_read, 0);
        tick();
        check("t1_read_granted", mem_read, 1);
        check("t1_address", mem_address, 16'h0010);
        tick();
        check("t1_done", req0_done, 1);
        check("t1_rdata", req0_rdata, 8'hA5);
        check("t1_read_dropped", mem_read, 0);
        check("t1_busy_cleared", req0_busy, 0);
        tick();
        check("t1_done_one_cycle", req0_done, 0);
        wait_idle(10);
        glog.delete();

        // Port-1 write with four wait cycles; memory drives junk on rdata.
        ready_delay = 4; mem_rdata = 8'h77;
        req1_valid = 1; req1_write = 1; req1_addr = 16'h0200; req1_wdata = 8'h3C;
        tick();
        req1_valid = 0;
        tick();
        n = 0;
        while (mem_write && n < 20) begin
            check("t2_addr_stable", mem_address, 16'h0200);
            check("t2_wdata_stable", mem_wdata, 8'h3C);
            n++;
            tick();
        end
`ifdef MEM_ARB_TIMEOUT_EN
        check("t2_busy_cycles", n, 4);
`else
        check("t2_busy_cycles", n, 5);
`endif
        check("t2_done", req1_done, 1);
        check("t2_rdata_unchanged", req1_rdata, 8'h00);
        wait_idle(10);
        glog.delete();

        // Arbitration order.
        ready_delay = 0; mem_rdata = 8'h5C;
        both_read(16'h0100, 16'h0101);
        expect_log(16'h0100, 16'h0101);
        both_read(16'h0110, 16'h0111);
        expect_log(16'h0110, 16'h0111);
        req0_valid = 1; req0_addr = 16'h0120;
        tick();
        req0_valid = 0;
        wait_idle(20);
        glog.delete();
        both_read(16'h0130, 16'h0131);
        expect_log(16'h0131, 16'h0130);

        // Other port arriving during BUSY waits for the IDLE edge.
        ready_delay = 2;
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0400;
        tick();
        req0_valid = 0;
        tick();
        req1_valid = 1; req1_write = 1; req1_addr = 16'h0401; req1_wdata = 8'hC3;
        tick();
        req1_valid = 0;
        check("t3_other_waits", mem_address, 16'h0400);
        wait_idle(30);
        expect_log(16'h0400, 16'h0401);

        // Valid while busy ignored; valid in the done cycle accepted.
        ready_delay = 2; mem_rdata = 8'h11;
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0300;
        tick();
        req0_addr = 16'h0333;
        n = 0;
        while (!req0_done && n < 20) begin
            tick();
            n++;
        end
        check("t4_done_seen", req0_done, 1);
        req0_addr = 16'h0344;
        tick();
        req0_valid = 0;
        wait_idle(20);
        expect_log(16'h0300, 16'h0344);

        // mem_ready while IDLE is ignored.
        idle_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_ready_no_done", req0_done | req1_done, 0);
            check("idle_ready_no_access", mem_read | mem_write, 0);
        end
        idle_ready = 0;
        tick(); tick();

        // Reset during BUSY.
        ready_delay = 255;
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0500;
        tick();
        req0_valid = 0;
        tick(); tick();
        check("t5_in_busy", mem_read, 1);
        reset = 1;
        tick();
        reset = 0;
        check("t5_read_dropped", mem_read, 0);
        check("t5_busy_cleared", req0_busy, 0);
        check("t5_no_done", req0_done, 0);
        ready_delay = 0; mem_rdata = 8'h5A;
        req1_valid = 1; req1_write = 0; req1_addr = 16'h0510;
        tick();
        req1_valid = 0;
        tick(); tick();
        check("t5_after_reset_done", req1_done, 1);
        check("t5_after_reset_rdata", req1_rdata, 8'h5A);
        wait_idle(10);
        glog.delete();

`ifdef MEM_ARB_TIMEOUT_EN
        // Abort after TB_TIMEOUT BUSY cycles, then ready on the last allowed cycle.
        ready_delay = 255; mem_rdata = 8'h42;
        req0_valid = 1; req0_write = 0; req0_addr = 16'h0600;
        tick();
        req0_valid = 0;
        tick();
        n = 0;
        while (mem_read && n < 20) begin
            n++;
            tick();
        end
        check("t6_abort_cycles", n, 4);
        check("t6_abort_done", req0_done, 1);
        check("t6_abort_timeout", timeout, 1);
        check("t6_abort_rdata", req0_rdata, 8'hFF);
        tick();
        check("t6_timeout_pulse", timeout, 0);
        wait_idle(10);
        ready_delay = 3;
        req0_valid = 1; req0_addr = 16'h0601;
        tick();
        req0_valid = 0;
        tick();
        n = 0;
        while (mem_read && n < 20) begin
            n++;
            tick();
        end
        check("t6_late_cycles", n, 4);
        check("t6_late_done", req0_done, 1);
        check("t6_late_no_timeout", timeout, 0);
        check("t6_late_rdata", req0_rdata, 8'h42);
        wait_idle(10);
        glog.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "time limit");
    end

endmodule
